game_control: RTL and testbench

- Top-level frame sequencer that sits directly upstream of the game datapath.
- Drives the datapath's one-hot phase strobes: init, idle, gen_move, check_collide, apply_act_link, move_enemies, draw_map, draw_link, draw_enemies.
- Advances on the datapath's done handshakes, so each frame runs in order: wait, compute, draw.
- Adds a per-phase watchdog so a hung sub-block cannot stall the game.

---
 rtl/game_control.sv | 217 +++++++++++++++++++++
 tb/tb_game_control.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_control.sv
// game_control: frame sequencer that drives the game datapath's one-hot phase strobes.
// Optional build macro GAME_PAUSE_EN adds a pause input that freezes the IDLE phase.
module game_control #(
    parameter int unsigned     INIT_CYCLES = 8,
    parameter int unsigned     TO_W        = 20,
    parameter logic [TO_W-1:0] TIMEOUT     = 20'd400000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        idle_done,
    input  logic        check_collide_done,
    input  logic        draw_map_done,
    input  logic        draw_link_done,
    input  logic        draw_enemies_done,
    output logic        init,
    output logic        idle,
    output logic        gen_move,
    output logic        check_collide,
    output logic        apply_act_link,
    output logic        move_enemies,
    output logic        draw_map,
    output logic        draw_link,
    output logic        draw_enemies,
    output logic [15:0] frame_count,
    output logic        timeout_err
`ifdef GAME_PAUSE_EN
    ,
    input  logic        pause
`endif
);

    localparam int unsigned       INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [TO_W-1:0]   WD_LAST   = TIMEOUT - TO_W'(1);
    localparam logic [TO_W-1:0]   WD_MAX    = '1;

    typedef enum logic [3:0] {
        S_INIT           = 4'd0,
        S_IDLE           = 4'd1,
        S_GEN_MOVE       = 4'd2,
        S_CHECK_COLLIDE  = 4'd3,
        S_APPLY_ACT_LINK = 4'd4,
        S_MOVE_ENEMIES   = 4'd5,
        S_DRAW_MAP       = 4'd6,
        S_DRAW_LINK      = 4'd7,
        S_DRAW_ENEMIES   = 4'd8
    } state_t;

    state_t            state_r;
    state_t            succ_s;
    state_t            next_s;
    logic [8:0]        strobe_r;
    logic [INIT_W-1:0] init_cnt_r;
    logic [TO_W-1:0]   wdog_r;
    logic [15:0]       frame_count_r;
    logic              timeout_err_r;

    logic              pause_s;
    logic              wait_ph_s;
    logic              done_in_s;
    logic              hold_s;
    logic              qual_s;
    logic              limit_s;
    logic              forced_s;
    logic              fault_s;

    // One-hot strobe pattern for a state; illegal encodings map to all-zero.
    function automatic logic [8:0] phase_strobe(input state_t st);
        logic [8:0] vec;
        vec = 9'b0_0000_0000;
        case (st)
            S_INIT:           vec = 9'b0_0000_0001;
            S_IDLE:           vec = 9'b0_0000_0010;
            S_GEN_MOVE:       vec = 9'b0_0000_0100;
            S_CHECK_COLLIDE:  vec = 9'b0_0000_1000;
            S_APPLY_ACT_LINK: vec = 9'b0_0001_0000;
            S_MOVE_ENEMIES:   vec = 9'b0_0010_0000;
            S_DRAW_MAP:       vec = 9'b0_0100_0000;
            S_DRAW_LINK:      vec = 9'b0_1000_0000;
            S_DRAW_ENEMIES:   vec = 9'b1_0000_0000;
            default:          vec = 9'b0_0000_0000;
        endcase
        return vec;
    endfunction

`ifdef GAME_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    // Successor state, wait-phase flag and the done input owned by the current phase.
    always_comb begin
        succ_s    = S_INIT;
        wait_ph_s = 1'b0;
        done_in_s = 1'b0;
        case (state_r)
            S_INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    succ_s = S_IDLE;
                end else begin
                    succ_s = S_INIT;
                end
            end
            S_IDLE: begin
                wait_ph_s = 1'b1;
                done_in_s = idle_done;
                succ_s    = S_GEN_MOVE;
            end
            S_GEN_MOVE: begin
                succ_s = S_CHECK_COLLIDE;
            end
            S_CHECK_COLLIDE: begin
                wait_ph_s = 1'b1;
                done_in_s = check_collide_done;
                succ_s    = S_APPLY_ACT_LINK;
            end
            S_APPLY_ACT_LINK: begin
                succ_s = S_MOVE_ENEMIES;
            end
            S_MOVE_ENEMIES: begin
                succ_s = S_DRAW_MAP;
            end
            S_DRAW_MAP: begin
                wait_ph_s = 1'b1;
                done_in_s = draw_map_done;
                succ_s    = S_DRAW_LINK;
            end
            S_DRAW_LINK: begin
                wait_ph_s = 1'b1;
                done_in_s = draw_link_done;
                succ_s    = S_DRAW_ENEMIES;
            end
            S_DRAW_ENEMIES: begin
                wait_ph_s = 1'b1;
                done_in_s = draw_enemies_done;
                succ_s    = S_IDLE;
            end
            default: begin
                succ_s = S_INIT;
            end
        endcase
    end

    // Qualify done (never on the entry cycle, where the watchdog is still 0) and apply the watchdog limit.
    always_comb begin
        hold_s   = pause_s & (state_r == S_IDLE);
        qual_s   = done_in_s & ~hold_s & (wdog_r != '0);
        limit_s  = wait_ph_s & ~hold_s & (wdog_r >= WD_LAST);
        fault_s  = (strobe_r != phase_strobe(state_r));
        forced_s = limit_s & ~qual_s & ~fault_s;
        if (fault_s) begin
            next_s = S_INIT;
        end else if (!wait_ph_s) begin
            next_s = succ_s;
        end else if (qual_s || limit_s) begin
            next_s = succ_s;
        end else begin
            next_s = state_r;
        end
    end

    // Sequencer state, registered strobes, init counter, watchdog and frame statistics.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= S_INIT;
            strobe_r      <= 9'b0_0000_0001;
            init_cnt_r    <= '0;
            wdog_r        <= '0;
            frame_count_r <= 16'd0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r  <= next_s;
            strobe_r <= phase_strobe(next_s);

            if ((state_r == S_INIT) && (next_s == S_INIT) && !fault_s) begin
                init_cnt_r <= init_cnt_r + INIT_W'(1);
            end else begin
                init_cnt_r <= '0;
            end

            // Watchdog restarts per phase, is frozen at 0 while paused, and saturates.
            if ((next_s != state_r) || hold_s) begin
                wdog_r <= '0;
            end else if (wait_ph_s && (wdog_r != WD_MAX)) begin
                wdog_r <= wdog_r + TO_W'(1);
            end else begin
                wdog_r <= wdog_r;
            end

            if ((state_r == S_DRAW_ENEMIES) && (next_s == S_IDLE)) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end

            if (forced_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign init           = strobe_r[0];
    assign idle           = strobe_r[1];
    assign gen_move       = strobe_r[2];
    assign check_collide  = strobe_r[3];
    assign apply_act_link = strobe_r[4];
    assign move_enemies   = strobe_r[5];
    assign draw_map       = strobe_r[6];
    assign draw_link      = strobe_r[7];
    assign draw_enemies   = strobe_r[8];
    assign frame_count    = frame_count_r;
    assign timeout_err    = timeout_err_r;

endmodule

// File: tb/tb_game_control.sv
// Randomized scoreboard bench for game_control: expected phase lengths come from a plan-level model.
module tb_game_control;

    localparam int T     = 16;
    localparam int NINIT = 8;
    localparam int M_PULSE = 0, M_FIRST = 1, M_NEVER = 2, M_HELD = 3, M_PAUSE = 4;

    typedef struct {
        logic [8:0] ph;
        int         len;
        int         fc;
        bit         err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        idle_done = 1'b0;
    logic        check_collide_done = 1'b0;
    logic        draw_map_done = 1'b0;
    logic        draw_link_done = 1'b0;
    logic        draw_enemies_done = 1'b0;
`ifdef GAME_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic        init, idle, gen_move, check_collide, apply_act_link;
    logic        move_enemies, draw_map, draw_link, draw_enemies;
    logic [15:0] frame_count;
    logic        timeout_err;
    logic [8:0]  strobes;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   pmode[5];
    int   po[5];
    bit   held_map;
    bit   abort_dl;
    int   mdl_fc;
    bit   mdl_err;
    int   wait_of[8] = '{0, -1, 1, -1, -1, 2, 3, 4};

    assign strobes = {draw_enemies, draw_link, draw_map, move_enemies, apply_act_link,
                      check_collide, gen_move, idle, init};

    game_control #(.INIT_CYCLES(NINIT), .TO_W(20), .TIMEOUT(20'd16)) dut (
        .clock(clock), .reset(reset),
        .idle_done(idle_done), .check_collide_done(check_collide_done),
        .draw_map_done(draw_map_done), .draw_link_done(draw_link_done),
        .draw_enemies_done(draw_enemies_done),
        .init(init), .idle(idle), .gen_move(gen_move), .check_collide(check_collide),
        .apply_act_link(apply_act_link), .move_enemies(move_enemies),
        .draw_map(draw_map), .draw_link(draw_link), .draw_enemies(draw_enemies),
        .frame_count(frame_count), .timeout_err(timeout_err)
`ifdef GAME_PAUSE_EN
        , .pause(pause)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Phase length implied by a plan: done is honoured from the second cycle, watchdog fires at T.
    function automatic int plan_dur(input int m, input int o);
        case (m)
            M_PULSE: return (o >= 1 && o <= T - 1) ? o + 1 : T;
            M_HELD:  return 2;
            M_PAUSE: return o + 2;
            default: return T;
        endcase
    endfunction

    function automatic bit plan_forced(input int m, input int o);
        case (m)
            M_PULSE: return !(o >= 1 && o <= T - 1);
            M_HELD:  return 1'b0;
            M_PAUSE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic own_done(input int m, input int o, input int i);
        case (m)
            M_PULSE: return (i == o);
            M_FIRST: return (i == 0);
            M_HELD:  return 1'b1;
            M_PAUSE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_cycle(input logic [4:0] dn);
        {draw_enemies_done, draw_link_done, draw_map_done, check_collide_done, idle_done} = dn;
        @(posedge clock);
        #1;
    endtask

    task automatic start_after_reset();
        exp_t e;
        reset = 1'b1;
        e.ph = 9'b0_0000_0001; e.len = NINIT; e.fc = 0; e.err = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < NINIT; i++) drive_cycle(5'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_idle_inputs();
        #2;
        chk("async_rst_strobes", int'(strobes), 1);
        chk("async_rst_frame_count", int'(frame_count), 0);
        chk("async_rst_timeout_err", int'(timeout_err), 0);
        exp_q.delete();
        mdl_fc  = 0;
        mdl_err = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        start_after_reset();
    endtask

    task automatic drive_idle_inputs();
        {draw_enemies_done, draw_link_done, draw_map_done, check_collide_done, idle_done} = 5'b0_0000;
    endtask

    task automatic set_all(input int m, input int o);
        for (int w = 0; w < 5; w++) begin
            pmode[w] = m;
            po[w]    = o;
        end
        held_map = 1'b0;
        abort_dl = 1'b0;
    endtask

    task automatic rand_plan();
        for (int w = 0; w < 5; w++) begin
            int r;
            r = int'($urandom_range(0, 11));
            po[w] = 0;
            if (r <= 6) begin
                pmode[w] = M_PULSE; po[w] = int'($urandom_range(1, 6));
            end else if (r == 7) begin
                pmode[w] = M_PULSE; po[w] = int'($urandom_range(7, 20));
            end else if (r == 8) begin
                pmode[w] = M_FIRST;
            end else if (r == 9) begin
                pmode[w] = M_NEVER;
            end else if (r == 10) begin
                pmode[w] = M_HELD;
            end else begin
                pmode[w] = M_PULSE; po[w] = T - 1;
            end
        end
        held_map = ($urandom_range(0, 5) == 0);
        if (held_map) pmode[2] = M_HELD;
        abort_dl = 1'b0;
    endtask

    // One frame: push the expected outcome of each phase, then drive its cycles.
    task automatic run_frame();
        for (int k = 0; k < 8; k++) begin
            int   w;
            int   dur;
            exp_t e;
            w = wait_of[k];
            if (w < 0) begin
                dur = 1;
            end else begin
                dur = plan_dur(pmode[w], po[w]);
                if (plan_forced(pmode[w], po[w])) mdl_err = 1'b1;
            end
            if (k == 7) mdl_fc = (mdl_fc + 1) % 65536;
            e.ph = 9'(1) << (k + 1); e.len = dur; e.fc = mdl_fc; e.err = mdl_err;
            exp_q.push_back(e);
            for (int i = 0; i < dur; i++) begin
                logic [4:0] dn;
                dn = 5'($urandom);
                if (held_map) dn[2] = 1'b1;
                if (held_map && k == 5) dn[3] = 1'b1;
                if (w >= 0) dn[w] = own_done(pmode[w], po[w], i);
`ifdef GAME_PAUSE_EN
                pause = (w == 0) && (pmode[0] == M_PAUSE) && (i < po[0]);
`endif
                if (abort_dl && k == 6 && i == 1) begin
                    do_reset();
                    return;
                end
                drive_cycle(dn);
            end
        end
    endtask

    // Monitor: measures each phase's length on the falling edge and checks it against the queue.
    initial begin : monitor
        logic [8:0] prev;
        int         len;
        bit         valid;
        exp_t       e;
        prev = 9'b0; len = 0; valid = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                valid = 1'b0;
                len   = 0;
                chk("rst_strobes", int'(strobes), 1);
                chk("rst_frame_count", int'(frame_count), 0);
                chk("rst_timeout_err", int'(timeout_err), 0);
            end else begin
                chk("onehot", $countones(strobes), 1);
                if (!valid) begin
                    prev = strobes; len = 1; valid = 1'b1;
                end else if (strobes == prev) begin
                    len++;
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_phase_end actual=%0d expected=none", prev);
                    end else begin
                        e = exp_q.pop_front();
                        chk("phase_id", int'(prev), int'(e.ph));
                        chk("phase_len", len, e.len);
                        chk("frame_count", int'(frame_count), e.fc);
                        chk("timeout_err", int'(timeout_err), int'(e.err));
                    end
                    prev = strobes; len = 1;
                end
            end
        end
    end

    initial begin : stimulus
        mdl_fc  = 0;
        mdl_err = 1'b0;
        drive_idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        start_after_reset();

        set_all(M_PULSE, 2);
        run_frame();
        set_all(M_PULSE, 3);
        held_map = 1'b1;
        pmode[2] = M_HELD;
        run_frame();
        set_all(M_PULSE, T - 1);
        run_frame();
`ifdef GAME_PAUSE_EN
        set_all(M_PULSE, 2);
        pmode[0] = M_PAUSE;
        po[0]    = 100;
        run_frame();
`endif
        set_all(M_PULSE, 2);
        pmode[1] = M_NEVER;
        run_frame();
        for (int f = 0; f < 20; f++) begin
            rand_plan();
            run_frame();
        end
        set_all(M_PULSE, 5);
        abort_dl = 1'b1;
        run_frame();
        for (int f = 0; f < 3; f++) begin
            rand_plan();
            run_frame();
        end
        repeat (3) drive_cycle(5'b0_0000);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
